click_track_generator: RTL



---
 rtl/click_track_generator_pkg.sv | 11 +
 rtl/click_track_generator_bpm_period_divider.sv | 53 +++++
 rtl/click_track_generator.sv | 112 +++++++++++
 3 files changed

// File: rtl/click_track_generator_pkg.sv
// click_track_generator_pkg: shared FSM type, tempo constants and clamp helper
package click_track_generator_pkg;
  typedef enum logic [1:0] {IDLE, CLICK, GAP} state_t;
  localparam int DEFAULT_BPM = 120;
  localparam int DIVIDEND_W = 20;
  localparam int DEFAULT_SAMPLE_RATE = 8000;
  localparam logic [DIVIDEND_W-1:0] DIVIDEND = DIVIDEND_W'(DEFAULT_SAMPLE_RATE * 60);
  function automatic logic [15:0] clamp_bpm(input logic [15:0] bpm, input logic [15:0] lo, input logic [15:0] hi);
    return bpm < lo ? lo : bpm > hi ? hi : bpm;
  endfunction
endpackage

// File: rtl/click_track_generator_bpm_period_divider.sv
// bpm_period_divider: restoring divider, one quotient bit per cycle, restartable
module bpm_period_divider
  import click_track_generator_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [15:0]           divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient
);
  logic [DIVIDEND_W-1:0] q;
  logic [15:0] rem;
  logic [15:0] d;
  logic [4:0] cnt;
  logic [16:0] shifted;
  logic fits;
  always_comb begin
    shifted = {rem, q[DIVIDEND_W-1]};
    fits = shifted >= {1'b0, d};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
      rem <= '0;
      d <= '0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        q <= dividend;
        rem <= '0;
        d <= divisor;
        cnt <= '0;
        busy <= 1'b1;
      end else if (busy) begin
        rem <= 16'(fits ? shifted - {1'b0, d} : shifted);
        q <= {q[DIVIDEND_W-2:0], fits};
        cnt <= cnt + 5'd1;
        if (cnt == 5'(DIVIDEND_W-1)) begin
          busy <= 1'b0;
          done <= 1'b1;
          quotient <= {q[DIVIDEND_W-2:0], fits};
        end
      end
    end
  end
endmodule

// File: rtl/click_track_generator.sv
// click_track_generator: metronome click-track sample stream at a programmable tempo
module click_track_generator
  import click_track_generator_pkg::*;
#(
  parameter int W           = 16,
  parameter int CLK_HZ      = 50000000,
  parameter int SAMPLE_RATE = 8000,
  parameter int CLICK_LEN   = 64,
  parameter int CLICK_AMP   = 12288,
  parameter int DECAY_SHIFT = 3,
  parameter int BPM_MIN     = 40,
  parameter int BPM_MAX     = 240
)(
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [15:0]         bpm_in,
  input  logic                bpm_load,
  output logic signed [W-1:0] sample_out,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                beat_marker,
  output logic [15:0]         bpm_active,
  output logic                bpm_busy,
  output logic                overrun
);
  localparam int CLK_DIV = CLK_HZ / SAMPLE_RATE;
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DIVIDEND_W-1:0] DIV_N = DIVIDEND_W'(SAMPLE_RATE * 60);
  localparam logic [DIVIDEND_W-1:0] RESET_PERIOD = DIVIDEND_W'(SAMPLE_RATE * 60 / DEFAULT_BPM);
  localparam logic [DIVIDEND_W-1:0] LAST_CLICK = DIVIDEND_W'(CLICK_LEN - 1);
  localparam logic [W-2:0] AMP = (W-1)'(CLICK_AMP);
  state_t state, state_nx;
  logic [CW-1:0] tcnt;
  logic tick, click_now, wrap, stall, div_done;
  logic [DIVIDEND_W-1:0] k, period, pend_period, div_q;
  logic [W-2:0] env;
  logic [15:0] pend_bpm, load_bpm, bpm_clamped;
  logic signed [W-1:0] tick_sample;
  assign tick = enable && tcnt == CW'(CLK_DIV - 1);
  assign stall = sample_valid && !sample_ready;
  assign bpm_clamped = clamp_bpm(bpm_in, 16'(BPM_MIN), 16'(BPM_MAX));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tcnt <= '0;
    else tcnt <= (!enable || tick) ? '0 : tcnt + CW'(1);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  // IDLE behaves as the first click sample once the tick arrives
  always_comb begin
    state_nx = state;
    if (!enable) state_nx = IDLE;
    else if (tick) state_nx = wrap ? CLICK : (click_now && k == LAST_CLICK) ? GAP : click_now ? CLICK : GAP;
  end
  always_comb begin
    click_now = state != GAP;
    wrap = k == period - 20'd1;
    tick_sample = click_now ? (k[2] ? -$signed({1'b0, env}) : $signed({1'b0, env})) : '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k <= '0;
      env <= AMP;
      period <= RESET_PERIOD;
      pend_period <= RESET_PERIOD;
      bpm_active <= 16'(DEFAULT_BPM);
      pend_bpm <= 16'(DEFAULT_BPM);
      load_bpm <= 16'(DEFAULT_BPM);
      sample_out <= '0;
      sample_valid <= 1'b0;
      beat_marker <= 1'b0;
      overrun <= 1'b0;
    end else begin
      beat_marker <= 1'b0;
      if (!enable) begin
        k <= '0;
        env <= AMP;
      end else if (tick) begin
        k <= wrap ? '0 : k + 20'd1;
        env <= wrap ? AMP : click_now ? env - (env >> DECAY_SHIFT) : env;
        if (wrap) begin
          period <= pend_period;
          bpm_active <= pend_bpm;
        end
      end
      // a stalled tick is dropped but the beat position above still advances
      if (tick && stall) overrun <= 1'b1;
      else if (tick) begin
        sample_out <= tick_sample;
        sample_valid <= 1'b1;
        beat_marker <= k == '0;
      end else if (sample_valid && sample_ready) sample_valid <= 1'b0;
      if (bpm_load) load_bpm <= bpm_clamped;
      if (div_done) begin
        pend_period <= div_q;
        pend_bpm <= load_bpm;
      end
    end
  end
  bpm_period_divider u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (bpm_load),
    .dividend (DIV_N),
    .divisor  (bpm_clamped),
    .busy     (bpm_busy),
    .done     (div_done),
    .quotient (div_q)
  );
endmodule
